// File: rtl/qspi_pkg.sv
// ---------------------------------------------------------------------------
// qspi_pkg
// Shared definitions for the quad-SPI flash responder:
//   - one-hot state encoding for the transaction FSM (7 states)
//   - the accepted opcode and the continuous-read mode match value
//   - default phase lengths for the command and mode phases
// ---------------------------------------------------------------------------
package qspi_pkg;

  typedef enum logic [6:0] {
    ST_IDLE   = 7'b000_0001,
    ST_CMD    = 7'b000_0010,
    ST_ADDR   = 7'b000_0100,
    ST_MODE   = 7'b000_1000,
    ST_DUMMY  = 7'b001_0000,
    ST_DATA   = 7'b010_0000,
    ST_IGNORE = 7'b100_0000
  } state_e;

  // Fast-read-quad-I/O opcode.
  localparam logic [7:0] CMD_QREAD = 8'hEB;

  // Mode byte bits [5:4] that arm continuous-read.
  localparam logic [1:0] CONT_MODE_MATCH = 2'b10;

  // Command bits on IO0 and clocks spent in the mode byte.
  localparam int CMD_BITS  = 8;
  localparam int MODE_CLKS = 2;

endpackage

// File: rtl/qspi_nibble_out.sv
// ---------------------------------------------------------------------------
// qspi_nibble_out
// Output byte path of the responder. Holds the byte captured from the
// backing memory during the dummy phase, the byte currently being shifted
// out, and the registered nibble driven onto the IO lines.
//
// Ports:
//   clk       in   SPI clock
//   rst_n     in   asynchronous active-low reset
//   clr       in   drive zero on the next edge (transaction ended)
//   cap_en    in   capture mem_data into the prefetch byte register
//   drv_hi    in   load a new byte and show its high nibble
//   drv_lo    in   show the low nibble of the byte being sent
//   use_cap   in   with drv_hi: take the byte from the capture register
//                  instead of straight from mem_data
//   mem_data  in   backing-memory read data
//   nib       out  nibble driven to the IO lines
// ---------------------------------------------------------------------------
module qspi_nibble_out (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       cap_en,
  input  logic       drv_hi,
  input  logic       drv_lo,
  input  logic       use_cap,
  input  logic [7:0] mem_data,
  output logic [3:0] nib
);

  logic [7:0] cap_q, cap_d;
  logic [7:0] cur_q, cur_d;
  logic [3:0] nib_q, nib_d;
  logic [7:0] src;

  // The first byte of a burst is fetched long before it is needed, so it
  // waits in cap_q. Later bytes arrive on mem_data exactly on the edge that
  // shows their high nibble and are used directly.
  assign src = use_cap ? cap_q : mem_data;

  always_comb begin
    cap_d = cap_q;
    cur_d = cur_q;
    nib_d = nib_q;
    if (cap_en) begin
      cap_d = mem_data;
    end
    if (clr) begin
      nib_d = 4'h0;
    end else if (drv_hi) begin
      cur_d = src;
      nib_d = src[7:4];
    end else if (drv_lo) begin
      nib_d = cur_q[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= 8'h00;
      cur_q <= 8'h00;
      nib_q <= 4'h0;
    end else begin
      cap_q <= cap_d;
      cur_q <= cur_d;
      nib_q <= nib_d;
    end
  end

  assign nib = nib_q;

endmodule

// File: rtl/qspi_flash_responder.sv
// ---------------------------------------------------------------------------
// qspi_flash_responder
// Quad-SPI flash responder for the 0xEB fast-read-quad-I/O transaction.
// Bytes are served from a synchronous backing memory whose read data is
// valid one clock after mem_rd. Clocked by the gated SPI clock (device view).
//
// Optional feature (macro QSPI_CONT_READ_EN): a mode byte with bits [5:4] =
// 2'b10 arms continuous-read, so the next transaction starts directly with
// the address. Without the macro the mode byte is ignored.
//
// Parameters:
//   ADDR_W        flash address width (multiple of 4)
//   MEM_AW        backing-memory address width (<= ADDR_W)
//   DUMMY_CYCLES  dummy clocks after the mode byte (>= 2)
//   CMD_QREAD     accepted opcode
//
// Ports:
//   clk       in   SPI clock
//   reset     in   asynchronous active-low reset
//   spiss     in   chip select, active-high
//   spiin     in   IO lines from the initiator, IO0 = bit 0
//   spiout    out  IO lines driven to the initiator
//   spioe     out  per-lane output enable
//   mem_rd    out  backing-memory read strobe
//   mem_addr  out  backing-memory byte address
//   mem_data  in   backing-memory read data
//   busy      out  FSM not idle
//   cmd_err   out  sticky unsupported-opcode flag, cleared by reset only
// ---------------------------------------------------------------------------
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int         ADDR_W       = 24,
  parameter int         MEM_AW       = 24,
  parameter int         DUMMY_CYCLES = 4,
  parameter logic [7:0] CMD_QREAD    = qspi_pkg::CMD_QREAD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spiss,
  input  logic [3:0]        spiin,
  output logic [3:0]        spiout,
  output logic [3:0]        spioe,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int         ADDR_NIB   = ADDR_W / 4;
  localparam logic [7:0] CMD_LAST   = 8'(qspi_pkg::CMD_BITS - 1);
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_NIB - 1);
  localparam logic [7:0] MODE_LAST  = 8'(qspi_pkg::MODE_CLKS - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        oe_q, oe_d;
  logic              hi_q, hi_d;
  logic              err_q, err_d;

  logic              nib_clr;
  logic              nib_cap;
  logic              nib_hi;
  logic              nib_lo;
  logic              nib_use_cap;

  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_next;
  logic              cont_armed;

`ifdef QSPI_CONT_READ_EN
  logic              cont_q, cont_d;
  logic [1:0]        mode_q, mode_d;
  assign cont_armed = cont_q;
`else
  assign cont_armed = 1'b0;
`endif

  assign addr_shift = {addr_q[ADDR_W-5:0], spiin};
  // Wraps modulo 2^ADDR_W.
  assign addr_next  = addr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    oe_d        = oe_q;
    hi_d        = hi_q;
    err_d       = err_q;
    nib_clr     = 1'b0;
    nib_cap     = 1'b0;
    nib_hi      = 1'b0;
    nib_lo      = 1'b0;
    nib_use_cap = 1'b0;
`ifdef QSPI_CONT_READ_EN
    cont_d      = cont_q;
    mode_d      = mode_q;
`endif

    if (!spiss) begin
      // Chip select low abandons whatever was in flight.
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      oe_d    = 4'h0;
      hi_d    = 1'b0;
      nib_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cont_armed) begin
            // Continuous-read: this edge already carries address nibble 1.
            addr_d  = {{(ADDR_W-4){1'b0}}, spiin};
            state_d = ST_ADDR;
          end else begin
            cmd_d   = {6'b0, spiin[0]};
            state_d = ST_CMD;
          end
          cnt_d = 8'd1;
        end

        ST_CMD: begin
          if (cnt_q == CMD_LAST) begin
            cnt_d = 8'd0;
            if ({cmd_q, spiin[0]} == CMD_QREAD) begin
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end else begin
            cmd_d = {cmd_q[5:0], spiin[0]};
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_ADDR: begin
          addr_d = addr_shift;
          if (cnt_q == ADDR_LAST) begin
            // Fetch the first byte now; it is captured at the first dummy edge.
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_shift[MEM_AW-1:0];
            state_d    = ST_MODE;
            cnt_d      = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_MODE: begin
          if (cnt_q == MODE_LAST) begin
            state_d = ST_DUMMY;
            cnt_d   = 8'd0;
`ifdef QSPI_CONT_READ_EN
            cont_d  = (mode_q == CONT_MODE_MATCH);
`endif
          end else begin
`ifdef QSPI_CONT_READ_EN
            // High nibble bits [1:0] are mode byte bits [5:4].
            mode_d = spiin[1:0];
`endif
            cnt_d  = cnt_q + 8'd1;
          end
        end

        ST_DUMMY: begin
          if (cnt_q == 8'd0) begin
            nib_cap = 1'b1;
          end
          if (cnt_q == DUMMY_LAST) begin
            // First high nibble comes from the captured byte; prefetch next.
            state_d     = ST_DATA;
            cnt_d       = 8'd0;
            oe_d        = 4'hF;
            hi_d        = 1'b1;
            nib_hi      = 1'b1;
            nib_use_cap = 1'b1;
            addr_d      = addr_next;
            mem_rd_d    = 1'b1;
            mem_addr_d  = addr_next[MEM_AW-1:0];
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_DATA: begin
          if (hi_q) begin
            nib_lo = 1'b1;
            hi_d   = 1'b0;
          end else begin
            // mem_data now holds the byte prefetched two edges ago.
            nib_hi     = 1'b1;
            hi_d       = 1'b1;
            addr_d     = addr_next;
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_next[MEM_AW-1:0];
          end
        end

        ST_IGNORE: begin
          oe_d = 4'h0;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          oe_d    = 4'h0;
          hi_d    = 1'b0;
          nib_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      cmd_q      <= 7'd0;
      addr_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      oe_q       <= 4'h0;
      hi_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      oe_q       <= oe_d;
      hi_q       <= hi_d;
      err_q      <= err_d;
    end
  end

`ifdef QSPI_CONT_READ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cont_q <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      cont_q <= cont_d;
      mode_q <= mode_d;
    end
  end
`endif

  qspi_nibble_out u_nibble_out (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (nib_clr),
    .cap_en   (nib_cap),
    .drv_hi   (nib_hi),
    .drv_lo   (nib_lo),
    .use_cap  (nib_use_cap),
    .mem_data (mem_data),
    .nib      (spiout)
  );

  assign spioe    = oe_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// ---------------------------------------------------------------------------
// tb_qspi_flash_responder
// Bench for qspi_flash_responder: a sparse backing memory with one clock of
// read latency, a recorder of memory reads, and scenario tasks that compare
// DUT outputs against expected nibbles and reads queued up front.
// ---------------------------------------------------------------------------
module tb_qspi_flash_responder;

  localparam int DUMMY = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spiss;
  logic [3:0]  spiin;
  logic [3:0]  spiout;
  logic [3:0]  spioe;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        busy;
  logic        cmd_err;

  logic [7:0]  mem [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_no = 0;

  logic [3:0]  exp_nib_q [$];
  logic [31:0] exp_rd_q [$];
  logic [31:0] obs_rd_q [$];

  always #5 clk = ~clk;

  qspi_flash_responder dut (
    .clk      (clk),
    .reset    (rst_n),
    .spiss    (spiss),
    .spiin    (spiin),
    .spiout   (spiout),
    .spioe    (spioe),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  // Synchronous backing memory: data valid one clock after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
  end

  // Record every read strobe with the transaction edge that raised it.
  always @(posedge clk) begin
    #1;
    if (mem_rd) obs_rd_q.push_back({8'(edge_no), mem_addr});
  end

  task automatic tick(input logic ss, input logic [3:0] d);
    @(negedge clk);
    spiss = ss;
    spiin = d;
    @(posedge clk);
    if (ss) edge_no++;
    else    edge_no = 0;
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(1'b1, {3'b000, b[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tick(1'b1, a[i*4 +: 4]);
  endtask

  task automatic send_mode(input logic [7:0] m);
    tick(1'b1, m[7:4]);
    tick(1'b1, m[3:0]);
  endtask

  task automatic send_dummy(input int n);
    repeat (n) tick(1'b1, 4'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    spiss = 1'b0;
    spiin = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({spiout, spioe, mem_rd, busy, cmd_err} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: spiout=%h spioe=%h mem_rd=%b busy=%b cmd_err=%b, required all 0",
               spiout, spioe, mem_rd, busy, cmd_err);
    end
    n_cmp++;
    if (mem_addr !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_mem_addr: got %h required 000000", mem_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    tick(1'b0, 4'h0);
  endtask

  task automatic test_basic_read();
    logic [3:0]  exp_n;
    logic [31:0] exp_r, got_r;
    obs_rd_q.delete();
    exp_nib_q = '{4'h5, 4'hA, 4'hC, 4'h3};
    exp_rd_q  = '{{8'd14, 24'h001234}, {8'd20, 24'h001235}, {8'd22, 24'h001236}};
    send_cmd(8'hEB);
    n_cmp++;
    if (busy !== 1'b1 || spioe !== 4'h0) begin
      n_bad++;
      $display("FAIL basic_after_cmd: busy=%b spioe=%h required busy=1 spioe=0", busy, spioe);
    end
    send_addr(24'h001234);
    send_mode(8'hFF);
    send_dummy(DUMMY - 1);
    n_cmp++;
    if (spioe !== 4'h0) begin
      n_bad++;
      $display("FAIL basic_oe_early: spioe=%h after edge %0d, required 0", spioe, edge_no);
    end
    send_dummy(1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(1'b1, 4'h0);
      exp_n = exp_nib_q.pop_front();
      n_cmp++;
      if (spioe !== 4'hF || spiout !== exp_n) begin
        n_bad++;
        $display("FAIL basic_data[%0d]: spioe=%h spiout=%h, required spioe=f spiout=%h",
                 i, spioe, spiout, exp_n);
      end
    end
    tick(1'b0, 4'h0);
    while (exp_rd_q.size() > 0) begin
      exp_r = exp_rd_q.pop_front();
      n_cmp++;
      if (obs_rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL basic_mem_rd: no read seen, required edge %0d addr %h", exp_r[31:24], exp_r[23:0]);
      end else begin
        got_r = obs_rd_q.pop_front();
        if (got_r !== exp_r) begin
          n_bad++;
          $display("FAIL basic_mem_rd: edge %0d addr %h, required edge %0d addr %h",
                   got_r[31:24], got_r[23:0], exp_r[31:24], exp_r[23:0]);
        end
      end
    end
    n_cmp++;
    if (obs_rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_extra_rd: %0d extra reads, required 0", obs_rd_q.size());
    end
  endtask

  task automatic test_bad_cmd();
    logic [3:0] exp_n;
    obs_rd_q.delete();
    send_cmd(8'h03);
    n_cmp++;
    if (cmd_err !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_cmd_flag: cmd_err=%b busy=%b required 1 1", cmd_err, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 4'hF);
      n_cmp++;
      if (spioe !== 4'h0) begin
        n_bad++;
        $display("FAIL bad_cmd_oe[%0d]: spioe=%h required 0", i, spioe);
      end
    end
    n_cmp++;
    if (obs_rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL bad_cmd_rd: %0d reads, required 0", obs_rd_q.size());
    end
    tick(1'b0, 4'h0);
    exp_nib_q = '{4'h5, 4'hA};
    send_cmd(8'hEB);
    send_addr(24'h001234);
    send_mode(8'hFF);
    send_dummy(DUMMY);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick(1'b1, 4'h0);
      exp_n = exp_nib_q.pop_front();
      n_cmp++;
      if (spioe !== 4'hF || spiout !== exp_n || cmd_err !== 1'b1) begin
        n_bad++;
        $display("FAIL after_bad_data[%0d]: spioe=%h spiout=%h cmd_err=%b, required f %h 1",
                 i, spioe, spiout, cmd_err, exp_n);
      end
    end
    tick(1'b0, 4'h0);
  endtask

  task automatic test_wrap();
    logic [3:0]  exp_n;
    logic [31:0] exp_r, got_r;
    obs_rd_q.delete();
    exp_nib_q = '{4'h1, 4'h1, 4'h2, 4'h2};
    exp_rd_q  = '{{8'd14, 24'hFFFFFF}, {8'd20, 24'h000000}, {8'd22, 24'h000001}};
    send_cmd(8'hEB);
    send_addr(24'hFFFFFF);
    send_mode(8'hFF);
    send_dummy(DUMMY);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(1'b1, 4'h0);
      exp_n = exp_nib_q.pop_front();
      n_cmp++;
      if (spioe !== 4'hF || spiout !== exp_n) begin
        n_bad++;
        $display("FAIL wrap_data[%0d]: spioe=%h spiout=%h, required spioe=f spiout=%h",
                 i, spioe, spiout, exp_n);
      end
    end
    tick(1'b0, 4'h0);
    while (exp_rd_q.size() > 0) begin
      exp_r = exp_rd_q.pop_front();
      n_cmp++;
      if (obs_rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL wrap_mem_rd: no read seen, required edge %0d addr %h", exp_r[31:24], exp_r[23:0]);
      end else begin
        got_r = obs_rd_q.pop_front();
        if (got_r !== exp_r) begin
          n_bad++;
          $display("FAIL wrap_mem_rd: edge %0d addr %h, required edge %0d addr %h",
                   got_r[31:24], got_r[23:0], exp_r[31:24], exp_r[23:0]);
        end
      end
    end
  endtask

  task automatic test_drop_mid_byte();
    logic [3:0] exp_n;
    send_cmd(8'hEB);
    send_addr(24'h001234);
    send_mode(8'hFF);
    send_dummy(DUMMY);
    tick(1'b1, 4'h0);
    n_cmp++;
    if (spiout !== 4'hA || edge_no != 21) begin
      n_bad++;
      $display("FAIL drop_pre: spiout=%h at edge %0d, required a at edge 21", spiout, edge_no);
    end
    tick(1'b0, 4'h0);
    n_cmp++;
    if (busy !== 1'b0 || spioe !== 4'h0) begin
      n_bad++;
      $display("FAIL drop_idle: busy=%b spioe=%h, required 0 0", busy, spioe);
    end
    exp_nib_q = '{4'h7, 4'hE};
    send_cmd(8'hEB);
    send_addr(24'h000010);
    send_mode(8'hFF);
    send_dummy(DUMMY);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick(1'b1, 4'h0);
      exp_n = exp_nib_q.pop_front();
      n_cmp++;
      if (spioe !== 4'hF || spiout !== exp_n) begin
        n_bad++;
        $display("FAIL drop_next_data[%0d]: spioe=%h spiout=%h, required f %h", i, spioe, spiout, exp_n);
      end
    end
    tick(1'b0, 4'h0);
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_n;
    send_cmd(8'hEB);
    send_addr(24'h000010);
    send_mode(8'hFF);
    send_dummy(2);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_pre_busy: busy=%b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (spioe !== 4'h0 || mem_rd !== 1'b0 || busy !== 1'b0 || cmd_err !== 1'b0 || spiout !== 4'h0) begin
      n_bad++;
      $display("FAIL areset_outputs: spioe=%h mem_rd=%b busy=%b cmd_err=%b spiout=%h, required all 0",
               spioe, mem_rd, busy, cmd_err, spiout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spiss = 1'b0;
    tick(1'b0, 4'h0);
    exp_nib_q = '{4'h7, 4'hE};
    send_cmd(8'hEB);
    send_addr(24'h000010);
    send_mode(8'hFF);
    send_dummy(DUMMY);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick(1'b1, 4'h0);
      exp_n = exp_nib_q.pop_front();
      n_cmp++;
      if (spioe !== 4'hF || spiout !== exp_n || cmd_err !== 1'b0) begin
        n_bad++;
        $display("FAIL areset_next_data[%0d]: spioe=%h spiout=%h cmd_err=%b, required f %h 0",
                 i, spioe, spiout, cmd_err, exp_n);
      end
    end
    tick(1'b0, 4'h0);
  endtask

`ifdef QSPI_CONT_READ_EN
  task automatic test_cont_read();
    logic [3:0] exp_n;
    send_cmd(8'hEB);
    send_addr(24'h001234);
    send_mode(8'hA0);
    send_dummy(DUMMY);
    n_cmp++;
    if (spiout !== 4'h5) begin
      n_bad++;
      $display("FAIL cont_first: spiout=%h required 5", spiout);
    end
    tick(1'b0, 4'h0);
    exp_nib_q = '{4'h9, 4'hB};
    send_addr(24'h000020);
    send_mode(8'hFF);
    send_dummy(DUMMY);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick(1'b1, 4'h0);
      exp_n = exp_nib_q.pop_front();
      n_cmp++;
      if (spioe !== 4'hF || spiout !== exp_n || edge_no != 12 + i) begin
        n_bad++;
        $display("FAIL cont_data[%0d]: spioe=%h spiout=%h edge=%0d, required f %h edge %0d",
                 i, spioe, spiout, edge_no, exp_n, 12 + i);
      end
    end
    tick(1'b0, 4'h0);
    exp_nib_q = '{4'h7, 4'hE};
    send_cmd(8'hEB);
    send_addr(24'h000010);
    send_mode(8'hFF);
    send_dummy(DUMMY);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick(1'b1, 4'h0);
      exp_n = exp_nib_q.pop_front();
      n_cmp++;
      if (spioe !== 4'hF || spiout !== exp_n) begin
        n_bad++;
        $display("FAIL cont_disarm_data[%0d]: spioe=%h spiout=%h, required f %h", i, spioe, spiout, exp_n);
      end
    end
    tick(1'b0, 4'h0);
  endtask
`endif

  initial begin
    mem['h001234] = 8'h5A;
    mem['h001235] = 8'hC3;
    mem['hFFFFFF] = 8'h11;
    mem['h000000] = 8'h22;
    mem['h000010] = 8'h7E;
    mem['h000020] = 8'h9B;

    test_reset();
    test_basic_read();
    test_bad_cmd();
    test_wrap();
    test_drop_mid_byte();
    test_async_reset();
`ifdef QSPI_CONT_READ_EN
    test_cont_read();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
